// File: rtl/tx_scheduler_pkg.sv
// Shared defaults, state encoding and width helpers for the UART transmit scheduler.
package tx_scheduler_pkg;

    localparam int TX_DATA_WIDTH   = 8;
    localparam int NUM_TX_REQ      = 4;
    localparam int TX_FRAME_CYCLES = 11;
    localparam int TX_GAP_CYCLES   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int count_width(input int frame_cycles, input int gap_cycles);
        return $clog2((frame_cycles > gap_cycles) ? frame_cycles : gap_cycles) + 1;
    endfunction

endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter
    import tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_TX_REQ,
    parameter int GW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GW-1:0]      rr_ptr,
    output logic [GW-1:0]      winner,
    output logic               any_valid
);

    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] rot;
        // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        rot       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            rot = req_valid >> idx;
            if (!any_valid && rot[0]) begin
                winner    = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// One byte per grant; data is held for the frame plus the inter-frame gap.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int  NUM_REQ      = NUM_TX_REQ,
    parameter int  DATA_WIDTH   = TX_DATA_WIDTH,
    parameter int  FRAME_CYCLES = TX_FRAME_CYCLES,
    parameter int  GAP_CYCLES   = TX_GAP_CYCLES,
    localparam int GW           = id_width(NUM_REQ)
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    localparam int             CW         = count_width(FRAME_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]  FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    tx_state_e             state;
    tx_state_e             state_nxt;
    logic [CW-1:0]         count;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         winner;
    logic                  any_valid;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign accept   = (state == ST_IDLE) && any_valid;
    assign sel_data = DATA_WIDTH'(req_data >> (int'(winner) * DATA_WIDTH));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (count == FRAME_LAST) begin
                    state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (count == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    end

    // The start strobe is the registered accept, so it lines up with the START state.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            tx_start <= 1'b0;
            data_out <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            tx_start <= accept;
            if (accept) begin
                data_out <= sel_data;
                grant_id <= winner;
                if (int'(winner) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= winner + 1'b1;
                end
            end
        end
    end

    // Frame counting starts at 1 because the START cycle is the first frame cycle.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            count <= '0;
        end else begin
            unique case (state)
                ST_START: begin
                    count <= CW'(1);
                end
                ST_FRAME, ST_GAP: begin
                    count <= (state_nxt != state) ? '0 : count + 1'b1;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: default 4-requester build plus a 1-requester, zero-gap build.
`timescale 1ns/1ps
module tb_tx_scheduler;

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    logic        tx_clk;
    logic        tx_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  data_out;
    logic [1:0]  grant_id;
    logic        busy;

    logic [0:0]  req_valid1;
    logic [7:0]  req_data1;
    logic [0:0]  req_ready1;
    logic        tx_start1;
    logic [7:0]  data_out1;
    logic [0:0]  grant_id1;
    logic        busy1;

    exp_t sb[$];
    exp_t sb1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    tx_scheduler dut (
        .tx_clk    (tx_clk),
        .tx_rst_n  (tx_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .data_out  (data_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    tx_scheduler #(
        .NUM_REQ      (1),
        .DATA_WIDTH   (8),
        .FRAME_CYCLES (11),
        .GAP_CYCLES   (0)
    ) dut1 (
        .tx_clk    (tx_clk),
        .tx_rst_n  (tx_rst_n),
        .req_valid (req_valid1),
        .req_data  (req_data1),
        .req_ready (req_ready1),
        .tx_start  (tx_start1),
        .data_out  (data_out1),
        .grant_id  (grant_id1),
        .busy      (busy1)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;
    always @(posedge tx_clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge tx_clk);
        tx_rst_n = 1'b0;
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        sb.delete();
        sb1.delete();
        step();
    endtask

    task automatic wait_start(input string tag, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: tx_start not seen within 40 cycles", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b, expected 0 within 40 cycles", tag, busy);
        end
    endtask

    task automatic sb_pop_compare(input string tag);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: tx_start with empty scoreboard, grant_id=%0d data_out=%h", tag, grant_id, data_out);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (grant_id !== e.id[1:0]) begin
                n_fail++;
                $display("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, e.id);
            end
            n_checks++;
            if (data_out !== e.data) begin
                n_fail++;
                $display("FAIL %s data_out: got %h expected %h", tag, data_out, e.data);
            end
        end
    endtask

    task automatic test_reset();
        tx_rst_n   = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_valid1 = '0;
        req_data1  = '0;
        #3;
        n_checks++;
        if ({tx_start, busy, grant_id, req_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got start=%b busy=%b grant=%0d ready=%b expected all 0",
                     tx_start, busy, grant_id, req_ready);
        end
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00", data_out);
        end
        n_checks++;
        if ({tx_start1, busy1, grant_id1, req_ready1, data_out1} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_dut1: got start=%b busy=%b grant=%0d data=%h expected all 0",
                     tx_start1, busy1, grant_id1, data_out1);
        end
        repeat (2) @(posedge tx_clk);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        sb.push_back('{id: 4'd0, data: 8'hA5});
        step();
        req_valid = '0;
        n_checks++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: tx_start=%b expected 1 one cycle after accept", tx_start);
        end
        sb_pop_compare("single");
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_ready_start: got %b expected 0000", req_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (data_out !== 8'hA5 || tx_start !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_hold%0d: data=%h start=%b busy=%b expected A5/0/1",
                         k, data_out, tx_start, busy);
            end
        end
        step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap: busy=%b expected 1", busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b expected 0 after 12 busy cycles", busy);
        end
    endtask

    task automatic test_round_robin();
        int t;
        int prev;
        apply_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{id: 4'(i % 4), data: 8'(8'h10 + i % 4)});
        end
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            wait_start($sformatf("rr%0d", i), t);
            if (t >= 0) begin
                sb_pop_compare($sformatf("rr%0d", i));
                if (prev >= 0) begin
                    n_checks++;
                    if (t - prev != 13) begin
                        n_fail++;
                        $display("FAIL rr_spacing%0d: got %0d cycles expected 13", i, t - prev);
                    end
                end
                prev = t;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_fairness();
        int t;
        wait_idle("fair_idle0");
        req_data[23:16] = 8'h22;
        req_valid       = 4'b0100;
        sb.push_back('{id: 4'd2, data: 8'h22});
        wait_start("fair_first", t);
        if (t >= 0) sb_pop_compare("fair_first");
        req_valid      = '0;
        req_data[7:0]  = 8'h30;
        req_data[23:16] = 8'h32;
        req_valid      = 4'b0101;
        sb.push_back('{id: 4'd0, data: 8'h30});
        sb.push_back('{id: 4'd2, data: 8'h32});
        wait_start("fair_wrap", t);
        if (t >= 0) sb_pop_compare("fair_wrap");
        req_valid[0] = 1'b0;
        wait_start("fair_next", t);
        if (t >= 0) sb_pop_compare("fair_next");
        req_valid = '0;
    endtask

    task automatic test_back_to_back_busy();
        int t0;
        int t;
        int k;
        int bad;
        wait_idle("busy_idle0");
        req_data[7:0] = 8'h40;
        req_valid     = 4'b0001;
        sb.push_back('{id: 4'd0, data: 8'h40});
        wait_start("busy_first", t0);
        if (t0 >= 0) sb_pop_compare("busy_first");
        req_valid = '0;
        repeat (5) step();
        req_data[31:24] = 8'h43;
        req_valid[3]    = 1'b1;
        #1;
        k   = 0;
        bad = 0;
        while (busy === 1'b1 && k < 20) begin
            if (req_ready !== 4'b0000) bad++;
            step();
            k++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_ready_low: req_ready high in %0d busy cycles, expected 0", bad);
        end
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL busy_ready_idle: got %b expected 1000", req_ready);
        end
        sb.push_back('{id: 4'd3, data: 8'h43});
        step();
        t = cyc;
        n_checks++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: tx_start=%b expected 1", tx_start);
        end else begin
            sb_pop_compare("busy_second");
        end
        n_checks++;
        if (t - t0 != 13) begin
            n_fail++;
            $display("FAIL busy_spacing: got %0d cycles expected 13", t - t0);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_frame();
        int t;
        int starts;
        wait_idle("rst_idle0");
        req_data[15:8] = 8'h55;
        req_valid      = 4'b0010;
        sb.push_back('{id: 4'd1, data: 8'h55});
        wait_start("rst_first", t);
        if (t >= 0) sb_pop_compare("rst_first");
        req_valid = '0;
        repeat (5) step();
        tx_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_start, busy, grant_id, req_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: start=%b busy=%b grant=%0d ready=%b expected all 0",
                     tx_start, busy, grant_id, req_ready);
        end
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h expected 00", data_out);
        end
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        sb.delete();
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx_start === 1'b1 || busy !== 1'b0) starts++;
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: %0d active cycles after reset, expected 0", starts);
        end
        req_data  = {8'h63, 8'h62, 8'h61, 8'h60};
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_ptr: req_ready=%b expected 0001", req_ready);
        end
        sb.push_back('{id: 4'd0, data: 8'h60});
        wait_start("rst_after", t);
        if (t >= 0) sb_pop_compare("rst_after");
        req_valid = '0;
        wait_idle("rst_idle1");
    endtask

    task automatic test_gap0_single_req();
        int   t;
        int   prev;
        bit   seen;
        exp_t e;
        req_data1  = 8'h7E;
        req_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) sb1.push_back('{id: 4'd0, data: 8'h7E});
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            t    = -1;
            for (int k = 0; k < 40 && !seen; k++) begin
                step();
                if (tx_start1 === 1'b1) begin
                    seen = 1'b1;
                    t    = cyc;
                end
            end
            n_checks++;
            if (!seen || sb1.size() == 0) begin
                n_fail++;
                $display("FAIL g0_start%0d: tx_start seen=%0d queued=%0d expected 1/nonzero", i, seen, sb1.size());
            end else begin
                e = sb1.pop_front();
                n_checks++;
                if (grant_id1 !== e.id[0:0] || data_out1 !== e.data) begin
                    n_fail++;
                    $display("FAIL g0_frame%0d: grant=%0d data=%h expected %0d/%h",
                             i, grant_id1, data_out1, e.id, e.data);
                end
                if (prev >= 0) begin
                    n_checks++;
                    if (t - prev != 12) begin
                        n_fail++;
                        $display("FAIL g0_spacing%0d: got %0d cycles expected 12", i, t - prev);
                    end
                end
                prev = t;
            end
        end
        req_valid1 = '0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_fairness();
        test_back_to_back_busy();
        test_reset_mid_frame();
        test_gap0_single_req();
        n_checks++;
        if (sb.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d entries left, expected 0", sb.size(), sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
